// File: rtl/systolic_input_skewer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_input_skewer
// Purpose  : Loads N beats of A rows / B columns, then streams them into an
//            NxN systolic array as skewed wavefronts (lane i delayed i cycles).
// Revision : 1.0 - initial release
// ============================================================================
module systolic_input_skewer #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*N*DW-1:0]        data_in,
  input  logic                     src_valid,
  output logic                     src_ready,
  input  logic                     dest_ready,
  output logic [N*DW-1:0]          a_out,
  output logic [N*DW-1:0]          b_out,
  output logic                     out_valid,
  output logic                     load_done,
  output logic                     tx_one_done,
  output logic                     stream_done,
  output logic [$clog2(N+1)-1:0]   beat_count
);

  localparam int BW = $clog2(N+1);
  localparam int CW = $clog2(N);
  localparam int TW = $clog2(2*N-1);

  localparam logic [BW-1:0] C_BC_LAST = BW'(N-1);
  localparam logic [TW-1:0] C_T_LAST  = TW'(2*N-2);

  localparam logic [0:0] S_LOAD   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [DW-1:0] a_q [N][N];
  logic [DW-1:0] b_q [N][N];

  logic w_accept;
  logic w_last;

  assign w_accept = (state_q == S_LOAD) && src_valid;
  assign w_last   = (state_q == S_STREAM) && (t_q == C_T_LAST) && dest_ready;

  // State, counters and operand buffers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      t_q     <= '0;
      bc_q    <= '0;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          a_q[i][k] <= '0;
          b_q[i][k] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      bc_q    <= bc_d;
      if (w_accept) begin
        // Beat b carries A row b and B column b.
        for (int k = 0; k < N; k++) begin
          a_q[bc_q[CW-1:0]][k] <= data_in[N*DW + k*DW +: DW];
          b_q[k][bc_q[CW-1:0]] <= data_in[k*DW +: DW];
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    bc_d    = bc_q;
    case (state_q)
      S_LOAD: begin
        if (src_valid) begin
          bc_d = bc_q + 1'b1;
          if (bc_q == C_BC_LAST) begin
            state_d = S_STREAM;
            t_d     = '0;
          end
        end
      end
      default: begin
        if (dest_ready) begin
          if (t_q == C_T_LAST) begin
            state_d = S_LOAD;
            t_d     = '0;
            bc_d    = '0;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Control outputs; pulses are masked while reset is asserted
  always_comb begin
    src_ready   = (state_q == S_LOAD);
    out_valid   = (state_q == S_STREAM);
    load_done   = (state_q == S_STREAM);
    tx_one_done = w_accept && !reset;
    stream_done = w_last && !reset;
    beat_count  = bc_q;
  end

  // Lane i shows element (t-i) of its row/column while 0 <= t-i < N
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [TW:0] w_diff;
    logic        w_live;

    assign w_diff = {1'b0, t_q} - (TW+1)'(gi);
    assign w_live = (state_q == S_STREAM) && !w_diff[TW] && (w_diff < (TW+1)'(N));
    assign a_out[gi*DW +: DW] = w_live ? a_q[gi][w_diff[CW-1:0]] : '0;
    assign b_out[gi*DW +: DW] = w_live ? b_q[w_diff[CW-1:0]][gi] : '0;
  end : g_lane

endmodule
`default_nettype wire

// File: tb/tb_systolic_input_skewer.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_input_skewer
// Purpose  : Directed self-checking bench for systolic_input_skewer (N=4, DW=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_input_skewer;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [2*N*DW-1:0] data_in;
  logic              src_valid;
  logic              src_ready;
  logic              dest_ready;
  logic [N*DW-1:0]   a_out;
  logic [N*DW-1:0]   b_out;
  logic              out_valid;
  logic              load_done;
  logic              tx_one_done;
  logic              stream_done;
  logic [2:0]        beat_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];

  always #5 clk = ~clk;

  systolic_input_skewer #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .dest_ready  (dest_ready),
    .a_out       (a_out),
    .b_out       (b_out),
    .out_valid   (out_valid),
    .load_done   (load_done),
    .tx_one_done (tx_one_done),
    .stream_done (stream_done),
    .beat_count  (beat_count)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // pat 0 is the reference pattern: A[i][k]=8'h(i+1)(k+1), B[k][j]=8'hA0+4k+j
  task automatic set_mats(input int pat);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (pat == 0) begin
          ma[i][k] = 8'((i+1)*16 + k + 1);
          mb[i][k] = 8'(8'hA0 + 4*i + k);
        end else begin
          ma[i][k] = 8'(pat*37 + i*8 + k*3 + 1);
          mb[i][k] = 8'(pat*91 + i*5 + k*11 + 2);
        end
      end
    end
  endtask

  function automatic logic [63:0] beat(input int b);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      v[32 + k*8 +: 8] = ma[b][k];
      v[k*8 +: 8]      = mb[k][b];
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_a(input int t);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*8 +: 8] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [31:0] exp_b(input int t);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*8 +: 8] = mb[t-j][j];
    return v;
  endfunction

  task automatic test_reset();
    reset      = 1'b1;
    src_valid  = 1'b1;
    dest_ready = 1'b1;
    data_in    = {$urandom, $urandom};
    cyc();
    data_in    = {$urandom, $urandom};
    cyc();
    #1;
    tests++;
    if (src_ready !== 1'b1 || out_valid !== 1'b0 || load_done !== 1'b0 ||
        tx_one_done !== 1'b0 || stream_done !== 1'b0 || beat_count !== 3'd0 ||
        a_out !== 32'h0 || b_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_hold: rdy=%b ov=%b ld=%b tx=%b sd=%b bc=%0d a=%h b=%h want 1 0 0 0 0 0 0 0",
               src_ready, out_valid, load_done, tx_one_done, stream_done, beat_count, a_out, b_out);
    end
    reset      = 1'b0;
    src_valid  = 1'b0;
    dest_ready = 1'b0;
    #1;
    tests++;
    if (src_ready !== 1'b1 || out_valid !== 1'b0 || beat_count !== 3'd0 || tx_one_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rdy=%b ov=%b bc=%0d tx=%b want 1 0 0 0",
               src_ready, out_valid, beat_count, tx_one_done);
    end
  endtask

  task automatic test_load(input bit hand, input bit gaps);
    dest_ready = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (gaps) begin
        src_valid = 1'b0;
        data_in   = {$urandom, $urandom};
        #1;
        tests++;
        if (tx_one_done !== 1'b0 || beat_count !== 3'(b) || src_ready !== 1'b1) begin
          fails++;
          $display("FAIL load_gap b=%0d: tx=%b bc=%0d rdy=%b want tx=0 bc=%0d rdy=1",
                   b, tx_one_done, beat_count, src_ready, b);
        end
        cyc();
      end
      src_valid = 1'b1;
      data_in   = beat(b);
      #1;
      tests++;
      if (tx_one_done !== 1'b1 || src_ready !== 1'b1 || out_valid !== 1'b0 ||
          beat_count !== 3'(b) || a_out !== 32'h0 || b_out !== 32'h0) begin
        fails++;
        $display("FAIL load_beat b=%0d: tx=%b rdy=%b ov=%b bc=%0d a=%h b=%h want tx=1 rdy=1 ov=0 bc=%0d a=0 b=0",
                 b, tx_one_done, src_ready, out_valid, beat_count, a_out, b_out, b);
      end
      cyc();
    end
    src_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1 || load_done !== 1'b1 || src_ready !== 1'b0 ||
        beat_count !== 3'd4 || a_out !== exp_a(0) || b_out !== exp_b(0)) begin
      fails++;
      $display("FAIL load_end: ov=%b ld=%b rdy=%b bc=%0d a=%h b=%h want 1 1 0 4 a=%h b=%h",
               out_valid, load_done, src_ready, beat_count, a_out, b_out, exp_a(0), exp_b(0));
    end
    if (hand) begin
      tests++;
      if (a_out !== 32'h0000_0011 || b_out !== 32'h0000_00A0) begin
        fails++;
        $display("FAIL load_first_wave: a=%h b=%h want 00000011 000000a0", a_out, b_out);
      end
    end
  endtask

  task automatic test_stream(input bit hand, input bit stall, input bit ignore);
    logic want_sd;
    for (int t = 0; t < 2*N-1; t++) begin
      if (stall && t == 2) begin
        for (int s = 0; s < 3; s++) begin
          dest_ready = 1'b0;
          #1;
          tests++;
          if (a_out !== exp_a(2) || b_out !== exp_b(2) || stream_done !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall s=%0d: a=%h b=%h sd=%b ov=%b want a=%h b=%h sd=0 ov=1",
                     s, a_out, b_out, stream_done, out_valid, exp_a(2), exp_b(2));
          end
          if (hand) begin
            tests++;
            if (a_out !== 32'h0031_2213 || b_out !== 32'h00A2_A5A8) begin
              fails++;
              $display("FAIL stall_hand s=%0d: a=%h b=%h want 00312213 00a2a5a8", s, a_out, b_out);
            end
          end
          cyc();
        end
      end
      dest_ready = 1'b1;
      src_valid  = ignore;
      data_in    = ignore ? {$urandom, $urandom} : '0;
      want_sd    = (t == 2*N-2);
      #1;
      tests++;
      if (a_out !== exp_a(t) || b_out !== exp_b(t) || out_valid !== 1'b1 || load_done !== 1'b1 ||
          beat_count !== 3'd4 || stream_done !== want_sd || src_ready !== 1'b0 || tx_one_done !== 1'b0) begin
        fails++;
        $display("FAIL stream t=%0d: a=%h b=%h ov=%b ld=%b bc=%0d sd=%b rdy=%b tx=%b want a=%h b=%h 1 1 4 sd=%b 0 0",
                 t, a_out, b_out, out_valid, load_done, beat_count, stream_done, src_ready, tx_one_done,
                 exp_a(t), exp_b(t), want_sd);
      end
      if (hand && t == 3) begin
        tests++;
        if (a_out !== 32'h4132_2314 || b_out !== 32'hA3A6_A9AC) begin
          fails++;
          $display("FAIL stream_t3: a=%h b=%h want 41322314 a3a6a9ac", a_out, b_out);
        end
      end
      if (hand && t == 6) begin
        tests++;
        if (a_out !== 32'h4400_0000 || b_out !== 32'hAF00_0000) begin
          fails++;
          $display("FAIL stream_t6: a=%h b=%h want 44000000 af000000", a_out, b_out);
        end
      end
      cyc();
    end
    src_valid  = 1'b0;
    dest_ready = 1'b0;
    #1;
    tests++;
    if (src_ready !== 1'b1 || out_valid !== 1'b0 || load_done !== 1'b0 || beat_count !== 3'd0 ||
        stream_done !== 1'b0 || a_out !== 32'h0 || b_out !== 32'h0) begin
      fails++;
      $display("FAIL stream_end: rdy=%b ov=%b ld=%b bc=%0d sd=%b a=%h b=%h want 1 0 0 0 0 0 0",
               src_ready, out_valid, load_done, beat_count, stream_done, a_out, b_out);
    end
  endtask

  task automatic test_reset_mid_stream();
    dest_ready = 1'b1;
    src_valid  = 1'b0;
    for (int t = 0; t < 3; t++) cyc();
    #1;
    tests++;
    if (a_out !== 32'h4132_2314 || b_out !== 32'hA3A6_A9AC) begin
      fails++;
      $display("FAIL midrst_pre: a=%h b=%h want 41322314 a3a6a9ac", a_out, b_out);
    end
    reset = 1'b1;
    cyc();
    reset      = 1'b0;
    dest_ready = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || load_done !== 1'b0 || beat_count !== 3'd0 || src_ready !== 1'b1 ||
        a_out !== 32'h0 || b_out !== 32'h0) begin
      fails++;
      $display("FAIL midrst_post: ov=%b ld=%b bc=%0d rdy=%b a=%h b=%h want 0 0 0 1 0 0",
               out_valid, load_done, beat_count, src_ready, a_out, b_out);
    end
  endtask

  initial begin
    reset      = 1'b1;
    src_valid  = 1'b0;
    dest_ready = 1'b0;
    data_in    = '0;

    test_reset();

    set_mats(0);
    test_load(1'b1, 1'b0);
    test_stream(1'b1, 1'b0, 1'b0);

    // back-to-back load immediately after the stream completes, stalled stream
    test_load(1'b1, 1'b0);
    test_stream(1'b1, 1'b1, 1'b0);

    set_mats(1);
    test_load(1'b0, 1'b1);
    test_stream(1'b0, 1'b0, 1'b1);

    set_mats(0);
    test_load(1'b1, 1'b0);
    test_reset_mid_stream();

    set_mats(2);
    test_load(1'b0, 1'b0);
    test_stream(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
